// File: rtl/segment_serializer_pkg.sv
// Shared types and constants for the segment_serializer: FSM states,
// 7-segment codes ({g,f,e,d,c,b,a}, active-high), and frame geometry.
package segment_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_e;

  localparam int FRAME_BITS = 48;
  localparam int CNT_W      = 6;
  localparam int DP_BIT     = 7;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/segment_serializer_bcd_to_7seg.sv
// Combinational BCD digit to 7-segment pattern; non-decimal codes blank.
module bcd_to_7seg
  import segment_serializer_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: default branch assigns seg_o on every path, so no latch is inferred.
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/segment_serializer.sv
// Serializes six BCD digits as 7-segment bytes into a 74HC595-style chain,
// advancing only on sr_tick. Define LEADING_ZERO_BLANK_EN to blank a zero hours_msd.
module segment_serializer
  import segment_serializer_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sr_tick,
  input  logic       en,
  input  logic [3:0] hours_msd,
  input  logic [3:0] hours_lsd,
  input  logic [3:0] minutes_msd,
  input  logic [3:0] minutes_lsd,
  input  logic [3:0] seconds_msd,
  input  logic [3:0] seconds_lsd,
  input  logic       pm,
  output logic       serial_out,
  output logic       latch_out,
  output logic       clk_out,
  output logic       frame_done
);

  localparam int SHIFT_W = DIGITS * 8;

  state_e               state_q, state_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 serial_out_q, serial_out_d;
  logic                 clk_out_q, clk_out_d;
  logic                 latch_out_q, latch_out_d;
  logic                 frame_done_q, frame_done_d;

  logic [3:0]           digit_w [DIGITS];
  logic [6:0]           seg_w   [DIGITS];
  logic [SHIFT_W-1:0]   snapshot_w;
  logic                 hm_blank_w;
  logic                 last_bit_w;

  // Index 0 is the first byte on the wire (hours_msd).
  assign digit_w[0] = hours_msd;
  assign digit_w[1] = hours_lsd;
  assign digit_w[2] = minutes_msd;
  assign digit_w[3] = minutes_lsd;
  assign digit_w[4] = seconds_msd;
  assign digit_w[5] = seconds_lsd;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_to_7seg u_dec (
      .bcd_i (digit_w[g]),
      .seg_o (seg_w[g])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign hm_blank_w = (hours_msd == 4'd0);
`else
  assign hm_blank_w = 1'b0;
`endif

  always_comb begin
    logic [7:0] byte_v;
    snapshot_w = '0;
    byte_v     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      byte_v = {1'b0, seg_w[i]};
      if (i == 1) byte_v[DP_BIT] = pm;
      if ((i == 0) && hm_blank_w) byte_v = '0;
      if (!en) byte_v = '0;
      snapshot_w[SHIFT_W-1-8*i -: 8] = byte_v;
    end
  end

  assign last_bit_w = (cnt_q == CNT_W'(SHIFT_W - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (sr_tick) begin
      case (state_q)
        ST_IDLE:     state_d = ST_LOAD;
        ST_LOAD:     state_d = ST_SHIFT_LO;
        ST_SHIFT_LO: state_d = ST_SHIFT_HI;
        ST_SHIFT_HI: state_d = last_bit_w ? ST_LATCH : ST_SHIFT_LO;
        ST_LATCH:    state_d = ST_LOAD;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values; everything holds on non-tick cycles.
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    serial_out_d = serial_out_q;
    clk_out_d    = clk_out_q;
    latch_out_d  = latch_out_q;
    frame_done_d = 1'b0;
    if (sr_tick) begin
      case (state_q)
        ST_LOAD: begin
          shift_d     = snapshot_w;
          cnt_d       = '0;
          latch_out_d = 1'b0;
        end
        ST_SHIFT_LO: begin
          serial_out_d = shift_q[SHIFT_W-1];
          clk_out_d    = 1'b0;
        end
        ST_SHIFT_HI: begin
          clk_out_d = 1'b1;
          shift_d   = {shift_q[SHIFT_W-2:0], 1'b0};
          cnt_d     = cnt_q + CNT_W'(1);
        end
        ST_LATCH: begin
          clk_out_d    = 1'b0;
          latch_out_d  = 1'b1;
          frame_done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      serial_out_q <= 1'b0;
      clk_out_q    <= 1'b0;
      latch_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      serial_out_q <= serial_out_d;
      clk_out_q    <= clk_out_d;
      latch_out_q  <= latch_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign serial_out = serial_out_q;
  assign clk_out    = clk_out_q;
  assign latch_out  = latch_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_segment_serializer.sv
// Self-checking bench for segment_serializer: table-driven frames plus
// hand-written sequences for en toggling, slow ticks and mid-frame reset.
module tb_segment_serializer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sr_tick = 1'b0;
  logic       en = 1'b0;
  logic       pm = 1'b0;
  logic [3:0] hm = '0, hl = '0, mm = '0, ml = '0, sm = '0, sl = '0;
  logic       serial_out, latch_out, clk_out, frame_done;

  segment_serializer #(.DIGITS(6)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sr_tick     (sr_tick),
    .en          (en),
    .hours_msd   (hm),
    .hours_lsd   (hl),
    .minutes_msd (mm),
    .minutes_lsd (ml),
    .seconds_msd (sm),
    .seconds_lsd (sl),
    .pm          (pm),
    .serial_out  (serial_out),
    .latch_out   (latch_out),
    .clk_out     (clk_out),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] HM0 = 8'h00;
`else
  localparam logic [7:0] HM0 = 8'h3F;
`endif

  typedef struct packed {
    logic [23:0] digits;
    logic        pm;
    logic        en;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [7];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Tick generator: sr_tick high one clk out of every tick_div.
  int tick_div = 1;
  int tick_ph  = 0;
  always @(negedge clk) begin
    tick_ph = (tick_ph + 1 >= tick_div) ? 0 : tick_ph + 1;
    sr_tick = (tick_ph == 0);
  end

  int   tick_ctr = 0;
  logic last_tick = 1'b0;
  always @(posedge clk) begin
    last_tick = sr_tick;
    if (sr_tick) tick_ctr++;
  end

  // Frame monitor: captures bits at clk_out rises, closes a frame at latch_out rise.
  logic [47:0] cap = '0, last_frame = '0;
  int   rises = 0, last_rises = 0, frame_cnt = 0;
  int   last_latch_tick = 0, last_period = 0;
  bit   period_valid = 0, last_period_valid = 0;
  int   frozen_err = 0, stab_err = 0, fd_err = 0;
  logic prev_so = 0, prev_co = 0, prev_lo = 0, prev_fd = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      cap          = '0;
      rises        = 0;
      period_valid = 0;
    end else begin
      if (!last_tick && (serial_out !== prev_so || clk_out !== prev_co || latch_out !== prev_lo))
        frozen_err++;
      if (clk_out && !prev_co) begin
        if (serial_out !== prev_so) stab_err++;
        cap = {cap[46:0], serial_out};
        rises++;
      end
      if (frame_done && prev_fd) fd_err++;
      if (frame_done && !(latch_out && !prev_lo)) fd_err++;
      if (latch_out && !prev_lo) begin
        if (!frame_done) fd_err++;
        last_frame        = cap;
        last_rises        = rises;
        cap               = '0;
        rises             = 0;
        last_period       = tick_ctr - last_latch_tick;
        last_period_valid = period_valid;
        last_latch_tick   = tick_ctr;
        period_valid      = 1;
        frame_cnt++;
      end
    end
    prev_so = serial_out;
    prev_co = clk_out;
    prev_lo = latch_out;
    prev_fd = frame_done;
  end

  task automatic apply(input vec_t v);
    hm = v.digits[23:20];
    hl = v.digits[19:16];
    mm = v.digits[15:12];
    ml = v.digits[11:8];
    sm = v.digits[7:4];
    sl = v.digits[3:0];
    pm = v.pm;
    en = v.en;
  endtask

  task automatic wait_frame(input string name);
    int start;
    bit ok;
    start = frame_cnt;
    ok    = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (frame_cnt != start) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no latch_out within 3000 clks", name);
    end
  endtask

  int rel_tick;
  int fc_before;
  bit reached;

  initial begin
    vecs[0] = '{digits: 24'h123456, pm: 1'b0, en: 1'b1, exp: 48'h065B4F666D7D};
    vecs[1] = '{digits: 24'h123456, pm: 1'b1, en: 1'b1, exp: 48'h06DB4F666D7D};
    vecs[2] = '{digits: 24'h123456, pm: 1'b1, en: 1'b0, exp: 48'h000000000000};
    vecs[3] = '{digits: 24'hC78905, pm: 1'b0, en: 1'b1, exp: 48'h00077F6F3F6D};
    vecs[4] = '{digits: 24'h095959, pm: 1'b1, en: 1'b1,
                exp: {HM0, 8'hEF, 8'h6D, 8'h6F, 8'h6D, 8'h6F}};
    vecs[5] = '{digits: 24'h2ABDEF, pm: 1'b1, en: 1'b1, exp: 48'h5B8000000000};
    vecs[6] = '{digits: 24'h888888, pm: 1'b1, en: 1'b1, exp: 48'h7FFF7F7F7F7F};

    // Reset state
    apply(vecs[0]);
    repeat (3) @(negedge clk);
    #1;
    check("reset_serial_out", 64'(serial_out), 64'd0);
    check("reset_clk_out",    64'(clk_out),    64'd0);
    check("reset_latch_out",  64'(latch_out),  64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    #1 reset_n = 1'b1;
    rel_tick = tick_ctr;

    // Table-driven frames, one tick per clk
    for (int i = 0; i < 7; i++) begin
      apply(vecs[i]);
      wait_frame($sformatf("frame%0d_wait", i));
      check($sformatf("frame%0d_data", i), 64'(last_frame), 64'(vecs[i].exp));
      check($sformatf("frame%0d_rises", i), 64'(last_rises), 64'd48);
      if (i == 0) check("first_latch_ticks", 64'(last_latch_tick - rel_tick), 64'd99);
      else        check($sformatf("frame%0d_period", i), 64'(last_period), 64'd98);
    end

    // en low at LOAD, inputs changed mid-frame: frame stays blank, next shows new digits
    apply('{digits: 24'h123456, pm: 1'b0, en: 1'b0, exp: 48'h0});
    repeat (30) @(negedge clk);
    #1 apply('{digits: 24'h888888, pm: 1'b0, en: 1'b1, exp: 48'h0});
    wait_frame("en_mid_wait");
    check("en_mid_blank", 64'(last_frame), 64'd0);
    wait_frame("en_next_wait");
    check("en_next_digits", 64'(last_frame), 64'h7F7F7F7F7F7F);

    // Slow ticks: every 3rd clk
    tick_div = 3;
    apply(vecs[0]);
    wait_frame("slow_first_wait");
    wait_frame("slow_wait");
    check("slow_data",   64'(last_frame), 64'(vecs[0].exp));
    check("slow_rises",  64'(last_rises), 64'd48);
    check("slow_period", 64'(last_period), 64'd98);
    check("slow_period_valid", 64'(last_period_valid), 64'd1);
    check("slow_frozen_errors", 64'(frozen_err), 64'd0);

    // Reset mid-frame after bit 20 has been clocked out
    reached = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (rises >= 21) begin
        reached = 1;
        break;
      end
    end
    check("reach_bit20", 64'(reached), 64'd1);
    check("pre_reset_serial_out", 64'(serial_out), 64'd1);
    fc_before = frame_cnt;
    #1 reset_n = 1'b0;
    #1;
    check("async_serial_out", 64'(serial_out), 64'd0);
    check("async_clk_out",    64'(clk_out),    64'd0);
    check("async_latch_out",  64'(latch_out),  64'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    rel_tick = tick_ctr;
    wait_frame("post_reset_wait");
    check("post_reset_frame_count", 64'(frame_cnt - fc_before), 64'd1);
    check("post_reset_data",  64'(last_frame), 64'(vecs[0].exp));
    check("post_reset_rises", 64'(last_rises), 64'd48);
    check("post_reset_ticks", 64'(last_latch_tick - rel_tick), 64'd99);

    check("serial_stability_errors", 64'(stab_err),   64'd0);
    check("frame_done_errors",       64'(fd_err),     64'd0);
    check("frozen_errors",           64'(frozen_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
